bcd_to_binary: RTL and testbench
================================

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 The block SHALL have no parameters; widths are fixed: 3 BCD digits in, 10-bit binary out.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 bcd  input  12  packed BCD: [11:8] hundreds, [7:4] tens, [3:0] units; sampled only on the accepting edge.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle pulse marking valid binary/error.
REQ-008 binary  output  10  converted value 0..999; held until the next accepted start.
REQ-009 error  output  1  high if the last accepted bcd had any digit > 9; held with binary.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-011 IDLE -> SHIFT on the edge where start=1 and all digits <= 9: latch bcd into a 22-bit work register {bcd, 10'b0}, set the shift counter to 0, clear error.
REQ-012 IDLE -> DONE on the edge where start=1 and any digit > 9: set error=1, binary=0, skip SHIFT.
REQ-013 The SHIFT state SHALL perform one step per cycle, as follows.
- Shift the work register right by 1.
- Then subtract 3 from each 4-bit BCD field whose post-shift value is >= 8.
- Increment the counter.
REQ-014 SHIFT SHALL run exactly 10 steps; on the edge performing step 10, load binary from work[9:0] and go to DONE.
REQ-015 In DONE, done SHALL be 1 for exactly one cycle; on the next edge -> IDLE.
REQ-016 Valid-path latency SHALL be 11 cycles: done is high in the 11th cycle after the accepting edge; error-path latency SHALL be 1 cycle.
REQ-017 start SHALL be ignored in SHIFT and DONE (no queuing); changes to bcd after acceptance SHALL NOT affect the result.
REQ-018 Back-to-back throughput SHALL be one conversion per 12 cycles (start reasserted in IDLE after DONE).
REQ-019 binary and error SHALL change only when entering DONE; they SHALL remain stable during SHIFT of a subsequent conversion.
REQ-020 Correction arithmetic SHALL be 4-bit modular per digit with no inter-digit borrow; after 10 steps of a valid input, the BCD field of the work register SHALL be 0.

Reset
REQ-021 On reset=1 at a clock edge the block SHALL take the following values.
- state = IDLE.
- busy = 0, done = 0, binary = 0, error = 0.
- Work register and counter cleared.
REQ-022 Reset asserted mid-SHIFT or in DONE SHALL abort the conversion with no done pulse; reset SHALL take priority over start.

Structure
REQ-023 The shared package bcd_pkg SHALL hold the following items.
- State enum (IDLE, SHIFT, DONE).
- Constants BCD_DIGITS=3, BIN_W=10, N_SHIFT=10.
- Digit-invalid threshold 9.
REQ-024 Sub-module bcd_digit_corr SHALL be a combinational 4-bit (>=8 ? -3 : pass) correction, instantiated once per digit.
REQ-025 The FSM, counter and work register SHALL reside in bcd_to_binary; outputs SHALL be registered.

Verification
REQ-026 Valid conversion: bcd=12'h999, start pulse -> done 11 cycles later, binary=10'd999 (0x3E7), error=0.
REQ-027 Zero and small values: bcd=12'h000 -> binary=0. bcd=12'h255 -> binary=0x0FF. bcd=12'h001 -> binary=1.
REQ-028 Invalid digit: bcd=12'h1A3 -> done 1 cycle after start, error=1, binary=0. A following valid 12'h042 -> binary=42, error=0.
REQ-029 Busy behaviour: start held high and bcd changed to 12'h777 during SHIFT of 12'h123 -> the bench SHALL check all of the following.
- Single done.
- binary=123.
- A second conversion begins only after return to IDLE.
REQ-030 Reset mid-operation: reset for 1 cycle at step 5 of 12'h500 -> no done pulse, outputs 0. A next start with 12'h500 -> binary=500.
REQ-031 Exhaustive sweep: all 1000 valid inputs -> binary equals the decimal value, latency 11, done width 1, busy low only in IDLE.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD-to-binary converter.
// Digit validity helper lives here so the FSM and any future users agree on it.
package bcd_pkg;

    localparam int unsigned BCD_DIGITS = 3;
    localparam int unsigned BIN_W      = 10;
    localparam int unsigned N_SHIFT    = 10;
    localparam int unsigned DIGIT_MAX  = 9;

    localparam int unsigned BCD_W  = 4 * BCD_DIGITS;
    localparam int unsigned WORK_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = $clog2(N_SHIFT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    function automatic logic bcd_has_bad_digit(input logic [BCD_W-1:0] b);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (b[4*i +: 4] > 4'(DIGIT_MAX)) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Per-digit correction for reverse double-dabble: fields that reached 8 or more
// after the right shift get 3 subtracted (4-bit modular, no borrow out).
module bcd_digit_corr (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd8) begin
            digit_o = digit_i - 4'd3;
        end
    end

endmodule

// File: rtl/bcd_to_binary.sv
// Three-digit packed BCD to 10-bit binary converter, one shift-and-correct step
// per cycle; invalid digits short-circuit straight to DONE with error set.
module bcd_to_binary
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BCD_W-1:0] bcd,
    output logic             busy,
    output logic             done,
    output logic [BIN_W-1:0] binary,
    output logic             error
);

    state_e              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    binary_q, binary_d;
    logic                error_q, error_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [WORK_W-1:0]   shifted;
    logic [WORK_W-1:0]   corrected;

    assign shifted = work_q >> 1;

    // Binary half passes through; only the BCD fields above it are corrected.
    assign corrected[BIN_W-1:0] = shifted[BIN_W-1:0];

    for (genvar d = 0; d < int'(BCD_DIGITS); d++) begin : g_corr
        bcd_digit_corr u_corr (
            .digit_i (shifted[BIN_W + 4*d +: 4]),
            .digit_o (corrected[BIN_W + 4*d +: 4])
        );
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        binary_d = binary_q;
        error_d  = error_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (bcd_has_bad_digit(bcd)) begin
                        binary_d = '0;
                        error_d  = 1'b1;
                        done_d   = 1'b1;
                        state_d  = StDone;
                    end else begin
                        work_d  = {bcd, {BIN_W{1'b0}}};
                        cnt_d   = '0;
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                work_d = corrected;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N_SHIFT - 1)) begin
                    binary_d = corrected[BIN_W-1:0];
                    error_d  = 1'b0;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            work_q   <= '0;
            cnt_q    <= '0;
            binary_q <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            binary_q <= binary_d;
            error_q  <= error_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign binary = binary_q;
    assign error  = error_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed and randomized checks of bcd_to_binary against a decimal-arithmetic
// reference model; outputs sampled on the falling edge.
module tb_bcd_to_binary;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] bcd;
    logic        busy;
    logic        done;
    logic [9:0]  binary;
    logic        error;

    int checks = 0;
    int errors = 0;

    // Model state: what binary/error must hold between conversions.
    int model_bin = 0;
    int model_err = 0;

    always #5 clk = ~clk;

    bcd_to_binary dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bcd    (bcd),
        .busy   (busy),
        .done   (done),
        .binary (binary),
        .error  (error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_bad(input logic [11:0] b);
        int h, t, u;
        h = int'(b[11:8]);
        t = int'(b[7:4]);
        u = int'(b[3:0]);
        return (h > 9 || t > 9 || u > 9) ? 1 : 0;
    endfunction

    function automatic int ref_val(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    // Call right after the accepting posedge. Counts falling edges until done,
    // checking busy and the held outputs on the way.
    task automatic wait_done(input string tag, input bit hold, output int lat,
                             output int n_done);
        lat    = 0;
        n_done = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            bcd = 12'($urandom);
            if (done) begin
                lat    = k;
                n_done = 1;
                break;
            end
            chk({tag, ".busy"}, 32'(busy), 32'd1);
            chk({tag, ".held_bin"}, 32'(binary), 32'(model_bin));
            chk({tag, ".held_err"}, 32'(error), 32'(model_err));
        end
    endtask

    task automatic conv(input string tag, input logic [11:0] b);
        int lat, nd, exp_lat;
        @(negedge clk);
        start = 1'b1;
        bcd   = b;
        @(posedge clk);
        wait_done(tag, 1'b0, lat, nd);
        exp_lat   = ref_bad(b) ? 1 : 11;
        model_err = ref_bad(b);
        model_bin = ref_bad(b) ? 0 : ref_val(b);
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".binary"}, 32'(binary), 32'(model_bin));
        chk({tag, ".error"}, 32'(error), 32'(model_err));
        @(negedge clk);
        chk({tag, ".done_width"}, 32'(done), 32'd0);
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat, nd, dones;
        logic [11:0] b;

        reset = 1'b1;
        start = 1'b0;
        bcd   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.binary", 32'(binary), 32'd0);
        chk("reset.error", 32'(error), 32'd0);
        reset = 1'b0;

        conv("h999", 12'h999);
        conv("h000", 12'h000);
        conv("h255", 12'h255);
        conv("h001", 12'h001);
        conv("h1A3", 12'h1A3);
        conv("h042", 12'h042);

        // start held and bcd changed during a conversion
        @(negedge clk);
        start = 1'b1;
        bcd   = 12'h123;
        @(posedge clk);
        dones = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bcd = 12'h777;
            if (done) begin
                dones++;
                chk("busy123.latency", 32'(k), 32'd11);
                chk("busy123.binary", 32'(binary), 32'd123);
                chk("busy123.error", 32'(error), 32'd0);
            end
        end
        chk("busy123.single_done", 32'(dones), 32'd1);
        chk("busy123.idle_gap", 32'(busy), 32'd0);
        model_bin = 123;
        model_err = 0;
        @(posedge clk);
        wait_done("second777", 1'b0, lat, nd);
        model_bin = 777;
        chk("second777.latency", 32'(lat), 32'd11);
        chk("second777.binary", 32'(binary), 32'd777);

        // reset after step 5 of h500
        @(negedge clk);
        start = 1'b1;
        bcd   = 12'h500;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid.busy", 32'(busy), 32'd0);
        chk("rst_mid.binary", 32'(binary), 32'd0);
        chk("rst_mid.error", 32'(error), 32'd0);
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("rst_mid.no_done", 32'(dones), 32'd0);
        model_bin = 0;
        model_err = 0;
        conv("h500", 12'h500);

        // random patterns, many with invalid digits
        for (int i = 0; i < 40; i++) begin
            b = 12'($urandom);
            conv("rand", b);
        end

        // exhaustive valid sweep
        for (int v = 0; v < 1000; v++) begin
            b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            conv("sweep", b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
